// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked byte-lane-aware responder for the 16-bit asynchronous SRAM bus
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   sram_ce_n      chip enable, active low
//   sram_oe_n      output enable, active low
//   sram_we_n      write enable, active low
//   sram_be_n      byte enables, active low; [1] -> dq[15:8], [0] -> dq[7:0]
//   sram_addr      word address; only the low DEPTH_LOG2 bits select a word
//   sram_dq        bidirectional data; driven here only during the read data phase
//   wr_count       accepted writes, saturating
//   rd_count       accepted reads, saturating
//   err_contention sticky: write and output enable asserted together while selected
module sram_responder #(
  parameter int    AW         = 18,
  parameter int    DW         = 16,
  parameter int    DEPTH_LOG2 = 12,
  parameter int    READ_LAT   = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sram_ce_n,
  input  logic          sram_oe_n,
  input  logic          sram_we_n,
  input  logic [1:0]    sram_be_n,
  input  logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_dq,
  output logic [31:0]   wr_count,
  output logic [31:0]   rd_count,
  output logic          err_contention
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAST  = READ_LAT - 1;
  localparam int HB    = DW / 2;

  // The array starts undefined; INIT_FILE is carried for configuration compatibility only.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  selected;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  contention;

  // Upper address bits are deliberately ignored so accesses wrap.
  if (DEPTH_LOG2 < AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^sram_addr[AW-1:DEPTH_LOG2];
  end

  assign idx        = sram_addr[DEPTH_LOG2-1:0];
  assign selected   = ~sram_ce_n;
  assign wr_acc     = selected & ~sram_we_n;
  // A write always wins, so a read needs we_n deasserted.
  assign rd_acc     = selected & sram_we_n & ~sram_oe_n;
  assign contention = selected & ~sram_we_n & ~sram_oe_n;

  // Memory has no reset: its contents survive rst, but a reset edge blocks writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      if (!sram_be_n[0]) mem[idx][HB-1:0]  <= sram_dq[HB-1:0];
      if (!sram_be_n[1]) mem[idx][DW-1:HB] <= sram_dq[DW-1:HB];
    end
  end

  // Read pipeline. Stage 0 snapshots the word at the sampling edge, so writes
  // landing while the read is in flight do not alter the returned data.
  logic          pipe_vld  [READ_LAT];
  logic [DW-1:0] pipe_data [READ_LAT];
  logic [1:0]    pipe_be   [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < READ_LAT; s++) pipe_vld[s] <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int s = 1; s < READ_LAT; s++) pipe_vld[s] <= pipe_vld[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      pipe_data[0] <= mem[idx];
      pipe_be[0]   <= sram_be_n;
    end
    for (int s = 1; s < READ_LAT; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_be[s]   <= pipe_be[s-1];
    end
  end

  // Drive decision uses the live bus controls, so the bus is released in the
  // same cycle the initiator raises oe_n or drops we_n.
  logic [1:0] lane_drv;
  assign lane_drv[0] = pipe_vld[LAST] & ~pipe_be[LAST][0] & rd_acc;
  assign lane_drv[1] = pipe_vld[LAST] & ~pipe_be[LAST][1] & rd_acc;

  assign sram_dq[HB-1:0]  = lane_drv[0] ? pipe_data[LAST][HB-1:0]  : {HB{1'bz}};
  assign sram_dq[DW-1:HB] = lane_drv[1] ? pipe_data[LAST][DW-1:HB] : {(DW-HB){1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count       <= 32'd0;
      rd_count       <= 32'd0;
      err_contention <= 1'b0;
    end else begin
      if (wr_acc && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
      if (rd_acc && rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
      if (contention) err_contention <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - bench for sram_responder at three latency/depth settings
module tb_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        ce_n  = 1'b1;
  logic        oe_n  = 1'b1;
  logic        we_n  = 1'b1;
  logic [1:0]  be_n  = 2'b11;
  logic [17:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic        tb_drv = 1'b0;

  // Pulled-up buses: a released lane reads back as 8'hFF.
  tri1 [15:0] dq0;
  tri1 [15:0] dq1;
  tri1 [15:0] dq2;
  assign dq0 = tb_drv ? wdata : 16'hzzzz;
  assign dq1 = tb_drv ? wdata : 16'hzzzz;
  assign dq2 = tb_drv ? wdata : 16'hzzzz;

  logic [31:0] wr0, wr1, wr2, rd0, rd1, rd2;
  logic        er0, er1, er2;

  sram_responder #(.AW(18), .DW(16), .DEPTH_LOG2(12), .READ_LAT(1), .INIT_FILE("")) u_l1 (
    .clk(clk), .rst(rst), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n), .sram_addr(addr), .sram_dq(dq0),
    .wr_count(wr0), .rd_count(rd0), .err_contention(er0));

  sram_responder #(.AW(18), .DW(16), .DEPTH_LOG2(12), .READ_LAT(3), .INIT_FILE("")) u_l3 (
    .clk(clk), .rst(rst), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n), .sram_addr(addr), .sram_dq(dq1),
    .wr_count(wr1), .rd_count(rd1), .err_contention(er1));

  sram_responder #(.AW(18), .DW(16), .DEPTH_LOG2(10), .READ_LAT(2), .INIT_FILE("")) u_l2 (
    .clk(clk), .rst(rst), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n), .sram_addr(addr), .sram_dq(dq2),
    .wr_count(wr2), .rd_count(rd2), .err_contention(er2));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- scoreboard model ----------------
  int          lat [3] = '{1, 3, 2};
  int          msk [3] = '{4095, 4095, 1023};
  logic [15:0] mm  [3][4096];
  logic [31:0] m_wr = 0;
  logic [31:0] m_rd = 0;
  logic        m_err = 1'b0;
  int          edge_n = 0;

  typedef struct {
    int              ed;
    logic [1:0]      be;
    logic [2:0][15:0] data;
  } rd_t;
  rd_t rq [$];

  task automatic model_edge();
    rd_t r;
    edge_n++;
    if (rst) begin
      rq.delete();
      m_wr  = 0;
      m_rd  = 0;
      m_err = 1'b0;
    end else if (!ce_n && !we_n) begin
      for (int i = 0; i < 3; i++) begin
        if (!be_n[0]) mm[i][int'(addr) & msk[i]][7:0]  = wdata[7:0];
        if (!be_n[1]) mm[i][int'(addr) & msk[i]][15:8] = wdata[15:8];
      end
      if (m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
      if (!oe_n) m_err = 1'b1;
    end else if (!ce_n && !oe_n) begin
      r.ed = edge_n;
      r.be = be_n;
      for (int i = 0; i < 3; i++) r.data[i] = mm[i][int'(addr) & msk[i]];
      rq.push_back(r);
      if (m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
    end
  endtask

  task automatic cmp(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s u%0d edge %0d: got %h expected %h", name, inst, edge_n, act, exp);
    end
  endtask

  function automatic logic [15:0] obs_dq(input int i);
    case (i)
      0:       return dq0;
      1:       return dq1;
      default: return dq2;
    endcase
  endfunction

  function automatic logic [31:0] obs_wr(input int i);
    case (i)
      0:       return wr0;
      1:       return wr1;
      default: return wr2;
    endcase
  endfunction

  function automatic logic [31:0] obs_rd(input int i);
    case (i)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic obs_er(input int i);
    case (i)
      0:       return er0;
      1:       return er1;
      default: return er2;
    endcase
  endfunction

  task automatic check_cycle();
    logic [15:0] exp;
    logic        rd_phase;
    rd_phase = !ce_n && we_n && !oe_n;
    while (rq.size() > 0 && rq[0].ed < edge_n - 4) void'(rq.pop_front());
    for (int i = 0; i < 3; i++) begin
      exp = 16'hFFFF;
      for (int k = 0; k < rq.size(); k++) begin
        if (rq[k].ed + lat[i] - 1 == edge_n && rd_phase) begin
          if (!rq[k].be[0]) exp[7:0]  = rq[k].data[i][7:0];
          if (!rq[k].be[1]) exp[15:8] = rq[k].data[i][15:8];
        end
      end
      if (!tb_drv) cmp("sb_dq", i, {16'h0, obs_dq(i)}, {16'h0, exp});
      cmp("sb_wr_count", i, obs_wr(i), m_wr);
      cmp("sb_rd_count", i, obs_rd(i), m_rd);
      cmp("sb_err", i, {31'h0, obs_er(i)}, {31'h0, m_err});
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic o,
                      input logic [1:0] b, input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; ce_n = c; we_n = w; oe_n = o; be_n = b; addr = a; wdata = d;
    tb_drv = !w;
    #1;
    check_cycle();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  // ---------------- vector table ----------------
  localparam int T_W = 0, T_R = 1, T_I = 2, T_O = 3, T_C = 4;

  typedef struct {
    logic        ce_n, we_n, oe_n;
    logic [1:0]  be_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  x_drv;
    logic [15:0] x_dq;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(input int t, input logic [1:0] b, input logic [17:0] a,
                              input logic [15:0] d, input logic [1:0] xd, input logic [15:0] xq);
    vec_t v;
    v.ce_n = (t == T_I);
    v.we_n = !(t == T_W || t == T_C);
    v.oe_n = !(t == T_R || t == T_C);
    v.be_n = b; v.addr = a; v.wdata = d; v.x_drv = xd; v.x_dq = xq;
    return v;
  endfunction

  function automatic logic [15:0] exp_pull(input logic [1:0] xd, input logic [15:0] xq);
    return {xd[1] ? xq[15:8] : 8'hFF, xd[0] ? xq[7:0] : 8'hFF};
  endfunction

  initial begin
    // expected dq columns are for u_l1 (READ_LAT=1)
    tbl[0]  = mk(T_W, 2'b00, 18'h00000, 16'h0F0F, 2'b00, 16'h0000);
    tbl[1]  = mk(T_W, 2'b00, 18'h00010, 16'hA5C3, 2'b00, 16'h0000);
    tbl[2]  = mk(T_R, 2'b00, 18'h00010, 16'h0000, 2'b00, 16'h0000);
    tbl[3]  = mk(T_R, 2'b00, 18'h00010, 16'h0000, 2'b11, 16'hA5C3);
    tbl[4]  = mk(T_W, 2'b10, 18'h00010, 16'h1234, 2'b00, 16'h0000);
    tbl[5]  = mk(T_R, 2'b01, 18'h00010, 16'h0000, 2'b00, 16'h0000);
    tbl[6]  = mk(T_R, 2'b11, 18'h00000, 16'h0000, 2'b10, 16'hA500);
    tbl[7]  = mk(T_I, 2'b00, 18'h00000, 16'h0000, 2'b00, 16'h0000);
    tbl[8]  = mk(T_W, 2'b00, 18'h00001, 16'h1111, 2'b00, 16'h0000);
    tbl[9]  = mk(T_W, 2'b00, 18'h00002, 16'h2222, 2'b00, 16'h0000);
    tbl[10] = mk(T_W, 2'b00, 18'h00003, 16'h3333, 2'b00, 16'h0000);
    tbl[11] = mk(T_R, 2'b00, 18'h00001, 16'h0000, 2'b00, 16'h0000);
    tbl[12] = mk(T_R, 2'b00, 18'h00002, 16'h0000, 2'b11, 16'h1111);
    tbl[13] = mk(T_R, 2'b00, 18'h00003, 16'h0000, 2'b11, 16'h2222);
    tbl[14] = mk(T_R, 2'b00, 18'h00003, 16'h0000, 2'b11, 16'h3333);
    tbl[15] = mk(T_R, 2'b00, 18'h00003, 16'h0000, 2'b11, 16'h3333);
    tbl[16] = mk(T_R, 2'b00, 18'h00003, 16'h0000, 2'b11, 16'h3333);
    tbl[17] = mk(T_O, 2'b00, 18'h00003, 16'h0000, 2'b00, 16'h0000);
    tbl[18] = mk(T_C, 2'b00, 18'h00020, 16'hBEEF, 2'b00, 16'h0000);
    tbl[19] = mk(T_R, 2'b00, 18'h00020, 16'h0000, 2'b00, 16'h0000);
    tbl[20] = mk(T_R, 2'b00, 18'h00020, 16'h0000, 2'b11, 16'hBEEF);
    tbl[21] = mk(T_I, 2'b00, 18'h00020, 16'h0000, 2'b00, 16'h0000);
    tbl[22] = mk(T_W, 2'b00, 18'h00400, 16'h5A5A, 2'b00, 16'h0000);
    tbl[23] = mk(T_I, 2'b00, 18'h00000, 16'h0000, 2'b00, 16'h0000);

    // reset with the bus idle
    tick();
    tick();

    for (int k = 0; k < NV; k++) begin
      step(1'b0, tbl[k].ce_n, tbl[k].we_n, tbl[k].oe_n, tbl[k].be_n, tbl[k].addr, tbl[k].wdata);
      if (k == 0) begin
        cmp("reset_wr_count", 0, wr0, 32'd0);
        cmp("reset_rd_count", 0, rd0, 32'd0);
        cmp("reset_err", 0, {31'h0, er0}, 32'd0);
      end
      if (tbl[k].we_n)
        cmp("tbl_dq", 0, {16'h0, dq0}, {16'h0, exp_pull(tbl[k].x_drv, tbl[k].x_dq)});
      tick();
    end

    // contention is sticky and the write counted
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 18'h0, 16'h0);
    cmp("err_sticky", 0, {31'h0, er0}, 32'd1);
    cmp("wr_total", 0, wr0, 32'd8);
    tick();

    // reset one edge after a READ_LAT=2 read: in-flight data is dropped
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 18'h00000, 16'h0);
    tick();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 18'h00000, 16'h0);
    cmp("rst_l2_dq_idle", 2, {16'h0, dq2}, 32'h0000FFFF);
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 18'h00000, 16'h0);
    cmp("post_rst_l2_dq", 2, {16'h0, dq2}, 32'h0000FFFF);
    cmp("post_rst_wr", 2, wr2, 32'd0);
    cmp("post_rst_rd", 2, rd2, 32'd0);
    cmp("post_rst_err", 2, {31'h0, er2}, 32'd0);
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 18'h00000, 16'h0);
    cmp("l1_after_rst", 0, {16'h0, dq0}, 32'h00000F0F);
    tick();
    step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 18'h00000, 16'h0);
    cmp("l2_wrap_read", 2, {16'h0, dq2}, 32'h00005A5A);
    tick();
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 18'h00000, 16'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
